// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage constants and the fetch queue entry type
package core_pkg;

  localparam int CORE_ADDR_WIDTH = 32;
  localparam int CORE_DATA_WIDTH = 32;
  localparam int CORE_FQ_DEPTH   = 2;
  localparam logic [CORE_ADDR_WIDTH-1:0] CORE_RESET_PC = 32'h0000_0000;

  // One fetched word together with the address it came from
  typedef struct packed {
    logic [CORE_ADDR_WIDTH-1:0] pc;
    logic [CORE_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small fetch queue of fetch_entry_t with push/pop/flush; flush wins over push
module fetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = CORE_FQ_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue still accepts a word when the head leaves in the same cycle
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy; storage is cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch stage: PC, imem addressing, redirect, fetch queue to decode (option IFETCH_MISALIGN_CHECK_EN)
module ifetch_unit
  import core_pkg::*;
#(
  parameter int                    ADDR_WIDTH = CORE_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = CORE_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = CORE_RESET_PC,
  parameter int                    FQ_DEPTH   = CORE_FQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc4,
  output logic                  fetch_fault
);

  localparam int FQ_CW = $clog2(FQ_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_redirect_target;
  logic                  w_fault_halt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_empty;
  logic [FQ_CW-1:0]      w_count;
  fetch_entry_t          w_push_entry;
  fetch_entry_t          w_head;

  assign imem_addr    = r_pc;
  assign id_valid     = ~w_empty;
  assign w_pop        = id_valid & id_ready;
  assign w_push       = ~w_fault_halt & ~redirect_valid &
                        ((w_count < FQ_CW'(FQ_DEPTH)) | w_pop);
  assign w_push_entry = '{pc: r_pc, instr: imem_data};

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_fault;

  // Misaligned target is loaded as-is so the faulting address stays visible
  assign w_redirect_target = redirect_pc;

  // Sticky fault: a misaligned redirect stops all further fetching until reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fault <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault_halt = r_fault;
`else
  // Without the check the low address bits are simply dropped
  assign w_redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
  assign w_fault_halt      = 1'b0;
`endif

  assign fetch_fault = w_fault_halt;

  // Program counter: redirect beats sequential advance; advance only when a word is queued
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_WIDTH'(4);
    end
  end

  fetch_fifo #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

  assign id_instr = w_head.instr;
  assign id_pc    = w_head.pc;
  assign id_pc4   = w_head.pc + ADDR_WIDTH'(4);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed vector table plus randomized run against a queue model of the fetch stage
module tb_ifetch_unit;

  localparam int FQ = 2;

  logic        clk;
  logic        nrst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    bit          ready;
    bit          rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          fault;
  } row_t;

  row_t tbl[$];

  ifetch_unit dut (
    .clk           (clk),
    .nrst          (nrst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign imem_data = mem_f(imem_addr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic row_t mk(bit rst, bit ready, bit rv, logic [31:0] rpc,
                              logic [31:0] addr, bit valid, logic [31:0] pc,
                              logic [31:0] instr, bit fault);
    row_t r;
    r.rst = rst; r.ready = ready; r.rv = rv; r.rpc = rpc;
    r.addr = addr; r.valid = valid; r.pc = pc; r.instr = instr; r.fault = fault;
    return r;
  endfunction

  task automatic pulse_reset();
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
  endtask

  task automatic rand_phase(int n);
    logic [31:0] mpc;
    bit          mfault;
    logic [63:0] q[$];
    bit          rdy, rv, pop;
    logic [31:0] rpc;
    int          sz;
    @(negedge clk);
    pulse_reset();
    mpc = 32'h0;
    mfault = 1'b0;
    q.delete();
    for (int i = 0; i < n; i++) begin
      chk("rnd_imem_addr", imem_addr, mpc);
      chk("rnd_id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
      chk("rnd_fault", {31'b0, fetch_fault}, {31'b0, mfault});
      if (q.size() != 0) begin
        chk("rnd_id_pc", id_pc, q[0][63:32]);
        chk("rnd_id_instr", id_instr, q[0][31:0]);
        chk("rnd_id_pc4", id_pc4, q[0][63:32] + 32'd4);
      end
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      if (i < n - 300 || $urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      pop = (q.size() != 0) && rdy;
      if (rv) begin
        q.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (rpc[1:0] != 2'b00) mfault = 1'b1;
        mpc = rpc;
`else
        mpc = {rpc[31:2], 2'b00};
`endif
      end else begin
        sz = q.size();
        if (pop) void'(q.pop_front());
        if (!mfault && (sz < FQ || pop)) begin
          q.push_back({mpc, mem_f(mpc)});
          mpc = mpc + 32'd4;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    nrst = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Straight-line fetch from reset with decode always ready
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  0, 32'h0, 32'h0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h4,  1, 32'h0, 32'h11, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h8,  1, 32'h4, 32'h22, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'hC,  1, 32'h8, 32'h33, 0));
    // Backpressure for five cycles, then drain in order
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h4,  1, 32'h0, 32'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h8,  1, 32'h0, 32'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h8,  1, 32'h0, 32'h11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h8,  1, 32'h0, 32'h11, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h8,  1, 32'h0, 32'h11, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'hC,  1, 32'h4, 32'h22, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h10, 1, 32'h8, 32'h33, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h14, 1, 32'hC, mem_f(32'hC), 0));
    // Redirect while the queue is full
    tbl.push_back(mk(0, 0, 1, 32'h100, 32'h14, 1, 32'hC, mem_f(32'hC), 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h100, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h104, 1, 32'h100, mem_f(32'h100), 0));
    // Redirect near the top of the address space, PC wraps to zero
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFF8, 32'h108, 1, 32'h104, mem_f(32'h104), 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'hFFFF_FFF8, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, mem_f(32'hFFFF_FFF8), 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, mem_f(32'hFFFF_FFFC), 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h4, 1, 32'h0, 32'h11, 0));
    // Misaligned redirect
    tbl.push_back(mk(0, 1, 1, 32'h102, 32'h8, 1, 32'h4, 32'h22, 0));
`ifdef IFETCH_MISALIGN_CHECK_EN
    tbl.push_back(mk(0, 1, 0, 0, 32'h102, 0, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h102, 0, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h102, 0, 32'h0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 1, 0, 0, 32'h100, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h104, 1, 32'h100, mem_f(32'h100), 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h108, 1, 32'h104, mem_f(32'h104), 0));
`endif

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      chk($sformatf("tbl%0d_imem_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].valid});
      chk($sformatf("tbl%0d_fault", i), {31'b0, fetch_fault}, {31'b0, tbl[i].fault});
      if (tbl[i].valid || tbl[i].rst) begin
        chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_id_instr", i), id_instr, tbl[i].instr);
        chk($sformatf("tbl%0d_id_pc4", i), id_pc4, tbl[i].pc + 32'd4);
      end
      id_ready       = tbl[i].ready;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      @(posedge clk);
      @(negedge clk);
    end

    rand_phase(3000);

    // Reset asserted between clock edges while the stream is running
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("arst_id_pc", id_pc, 32'h0);
    chk("arst_id_instr", id_instr, 32'h0);
    chk("arst_id_pc4", id_pc4, 32'h4);
    chk("arst_fault", {31'b0, fetch_fault}, 32'h0);
    #1;
    nrst = 1'b1;
    #1;
    chk("arst_release_addr", imem_addr, 32'h0);
    chk("arst_release_valid", {31'b0, id_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
